// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned SC_W    = $clog2(OS_RATE);

  // Sample-counter positions inside one bit period
  localparam int unsigned SMP_LO  = 7;
  localparam int unsigned SMP_MID = 8;
  localparam int unsigned SMP_HI  = 9;
  localparam int unsigned SMP_END = 15;

  // Two-out-of-three vote across the mid-bit samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle pulse every OS_DIV clocks, phase-resettable.
module uart_os_tick #(
  parameter int unsigned OS_DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned    CNT_W   = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OS_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tick_c = (cnt_q == CNT_MAX);

  // Free-running divider; a clear restarts the phase at zero
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clr || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver: 2-flop input sync, 16x oversampling with 3-sample majority,
// optional parity, framing and break detection.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OS_DIV     = 27,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_data_valid,
  output logic                 o_rx_data_error,
  output logic                 o_rx_parity_error,
  output logic                 o_rx_break,
  output logic                 o_rx_busy
);

  localparam int unsigned BC_W = $clog2(DATA_BITS);

  // Synchronizer and edge history
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;
  logic       rx_prev_q, rx_prev_d;
  logic [1:0] fill_q, fill_d;

  // Frame state
  rx_state_t            state_q, state_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [1:0]           smp_q, smp_d;
  logic [BC_W-1:0]      bc_q, bc_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;

  // Registered outputs
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 brk_q, brk_d;
  logic                 busy_q, busy_d;

  logic tick_c, clr_c, fall_c, maj_c, at_hi_c, at_end_c, par_bad_c, is_brk_c;

  uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (clr_c),
    .o_tick_c(tick_c)
  );

  assign o_rx_data         = data_q;
  assign o_rx_data_valid   = valid_q;
  assign o_rx_data_error   = ferr_q;
  assign o_rx_parity_error = perr_q;
  assign o_rx_break        = brk_q;
  assign o_rx_busy         = busy_q;

  // Synchronizer chain; fill marks when real line samples have reached rx_s
  always_comb begin
    rx_meta_d = i_rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    fill_d    = {fill_q[0], 1'b1};
  end

  // Bit decoding helpers
  always_comb begin
    fall_c    = rx_prev_q & ~rx_s_q;
    maj_c     = maj3(smp_q[0], smp_q[1], rx_s_q);
    at_hi_c   = tick_c && (sc_q == SC_W'(SMP_HI));
    at_end_c  = tick_c && (sc_q == SC_W'(SMP_END));
    par_bad_c = (PARITY_EN != 0) && (((^sh_q) ^ (PARITY_ODD != 0)) != par_q);
    is_brk_c  = (sh_q == '0) && ((PARITY_EN == 0) || !par_q);
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    smp_d   = smp_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    brk_d   = 1'b0;
    clr_c   = 1'b0;

    if (tick_c && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
      sc_d = sc_q + SC_W'(1);
      if (sc_q == SC_W'(SMP_LO))  smp_d[0] = rx_s_q;
      if (sc_q == SC_W'(SMP_MID)) smp_d[1] = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d = ST_START;
          sc_d    = '0;
          clr_c   = 1'b1;
        end
      end
      ST_START: begin
        if (at_hi_c && maj_c) begin
          state_d = ST_IDLE;
        end else if (at_end_c) begin
          state_d = ST_DATA;
          bc_d    = '0;
        end
      end
      ST_DATA: begin
        if (at_hi_c) begin
          sh_d = {maj_c, sh_q[DATA_BITS-1:1]};
        end
        if (at_end_c) begin
          if (bc_q == BC_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bc_d = bc_q + BC_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (at_hi_c) begin
          par_d = maj_c;
        end
        if (at_end_c) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Resolve mid stop bit so a back-to-back start edge is never missed
        if (at_hi_c) begin
          state_d = ST_IDLE;
          if (!maj_c) begin
            ferr_d = 1'b1;
            if (is_brk_c) begin
              brk_d   = 1'b1;
              state_d = ST_WAIT_IDLE;
            end else begin
              data_d = sh_q;
            end
          end else if (par_bad_c) begin
            perr_d = 1'b1;
            data_d = sh_q;
          end else begin
            valid_d = 1'b1;
            data_d  = sh_q;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (fill_q[1] && rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_WAIT_IDLE});
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= '0;
      state_q   <= ST_WAIT_IDLE;
      sc_q      <= '0;
      smp_q     <= '0;
      bc_q      <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      brk_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      sc_q      <= sc_d;
      smp_q     <= smp_d;
      bc_q      <= bc_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      brk_q     <= brk_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: one DUT without parity, one with even parity.
module tb_uart_rx_os16;

  localparam int unsigned DW  = 8;
  localparam int unsigned OSD = 4;
  localparam int unsigned BIT = 16 * OSD;

  localparam logic [3:0] F_VALID = 4'b0001;
  localparam logic [3:0] F_PERR  = 4'b0010;
  localparam logic [3:0] F_FERR  = 4'b0100;
  localparam logic [3:0] F_BRK   = 4'b1000;

  typedef struct {
    logic [3:0]  flags;
    logic [7:0]  data;
    int unsigned t_lo;
    int unsigned t_hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_np = 1'b1;
  logic rx_pe = 1'b1;

  logic [DW-1:0] data_np, data_pe;
  logic v_np, fe_np, pe_np, bk_np, busy_np;
  logic v_pe, fe_pe, pe_pe, bk_pe, busy_pe;

  exp_t q_np[$];
  exp_t q_pe[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [7:0] last_np = 8'h00;
  logic [7:0] last_pe = 8'h00;

  uart_rx_os16 #(.DATA_BITS(DW), .OS_DIV(OSD), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_np),
    .o_rx_data(data_np), .o_rx_data_valid(v_np), .o_rx_data_error(fe_np),
    .o_rx_parity_error(pe_np), .o_rx_break(bk_np), .o_rx_busy(busy_np)
  );

  uart_rx_os16 #(.DATA_BITS(DW), .OS_DIV(OSD), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_pe),
    .o_rx_data(data_pe), .o_rx_data_valid(v_pe), .o_rx_data_error(fe_pe),
    .o_rx_parity_error(pe_pe), .o_rx_break(bk_pe), .o_rx_busy(busy_pe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int unsigned act, input int unsigned lo,
                         input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference outcome of one frame, straight from the framing rules
  function automatic exp_t model(input bit pe, input logic [7:0] d, input bit pb,
                                 input bit sb, input logic [7:0] last);
    exp_t e;
    e.data  = d;
    e.t_lo  = 0;
    e.t_hi  = 0;
    if (!sb) begin
      if (d == 8'h00 && (!pe || !pb)) begin
        e.flags = F_BRK | F_FERR;
        e.data  = last;
      end else begin
        e.flags = F_FERR;
      end
    end else if (pe && (pb != ($countones(d) % 2 == 1))) begin
      e.flags = F_PERR;
    end else begin
      e.flags = F_VALID;
    end
    return e;
  endfunction

  task automatic push_exp(input bit pe, input logic [7:0] d, input bit pb, input bit sb,
                          input int unsigned t0);
    exp_t e;
    int unsigned nom;
    e   = model(pe, d, pb, sb, pe ? last_pe : last_np);
    nom = (1 + DW + (pe ? 1 : 0)) * BIT + 10 * OSD;
    e.t_lo = t0 + nom - 4;
    e.t_hi = t0 + nom + 4;
    if (pe) begin
      last_pe = e.data;
      q_pe.push_back(e);
    end else begin
      last_np = e.data;
      q_np.push_back(e);
    end
  endtask

  task automatic set_rx(input bit pe, input logic v);
    if (pe) rx_pe = v;
    else    rx_np = v;
  endtask

  task automatic hold(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit pe, input logic [7:0] d, input bit pb, input bit sb);
    set_rx(pe, 1'b0);
    push_exp(pe, d, pb, sb, cyc);
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      set_rx(pe, d[i]);
      hold(BIT);
    end
    if (pe) begin
      set_rx(pe, pb);
      hold(BIT);
    end
    set_rx(pe, sb);
    hold(BIT);
    set_rx(pe, 1'b1);
  endtask

  task automatic mon(input bit pe, input logic [3:0] fl, input logic [7:0] d);
    exp_t e;
    string tag;
    tag = pe ? "pe" : "np";
    if ((pe && q_pe.size() == 0) || (!pe && q_np.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_pulse: got flags 0x%0h data 0x%0h, expected no pulse (cycle %0d)",
               tag, fl, d, cyc);
      return;
    end
    if (pe) e = q_pe.pop_front();
    else    e = q_np.pop_front();
    chk({tag, "_flags"}, 32'(fl), 32'(e.flags));
    chk({tag, "_data"}, 32'(d), 32'(e.data));
    chk_rng({tag, "_latency"}, cyc, e.t_lo, e.t_hi);
  endtask

  // Monitor: pops one expectation per presented result pulse
  always @(negedge clk) begin
    if (v_np | fe_np | pe_np | bk_np) mon(1'b0, {bk_np, fe_np, pe_np, v_np}, data_np);
    if (v_pe | fe_pe | pe_pe | bk_pe) mon(1'b1, {bk_pe, fe_pe, pe_pe, v_pe}, data_pe);
  end

  task automatic chk_outs_zero(input string name);
    chk({name, "_pulses"}, 32'({v_np, fe_np, pe_np, bk_np}), 32'd0);
    chk({name, "_data"}, 32'(data_np), 32'd0);
    chk({name, "_busy"}, 32'(busy_np), 32'd0);
  endtask

  initial begin
    logic [7:0]  d;
    bit          pe, pb, sb;
    int unsigned wait_cyc;

    // Reset state
    hold(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    hold(BIT);

    // Good frame
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    hold(2);
    chk("good_busy_after", 32'(busy_np), 32'd0);
    chk("good_drained", q_np.size(), 32'd0);
    hold(BIT);

    // Back-to-back with zero idle gap
    send_frame(1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
    hold(BIT);

    // Short low glitch: false start
    set_rx(1'b0, 1'b0);
    hold(16);
    set_rx(1'b0, 1'b1);
    hold(4);
    chk("glitch_busy_start", 32'(busy_np), 32'd1);
    hold(4 * BIT);
    chk("glitch_busy_idle", 32'(busy_np), 32'd0);

    // Framing error
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    hold(BIT);

    // Break: 12 bit times low, then a normal frame once the line has recovered
    set_rx(1'b0, 1'b0);
    push_exp(1'b0, 8'h00, 1'b0, 1'b0, cyc);
    hold(12 * BIT);
    chk("break_busy_wait", 32'(busy_np), 32'd0);
    set_rx(1'b0, 1'b1);
    hold(BIT);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    hold(BIT);

    // Even parity
    send_frame(1'b1, 8'h07, 1'b1, 1'b1);
    send_frame(1'b1, 8'h07, 1'b0, 1'b1);
    hold(BIT);

    // Reset in the middle of data bit 4, line held low through release
    d = 8'hA5;
    set_rx(1'b0, 1'b0);
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      set_rx(1'b0, d[i]);
      hold(BIT);
    end
    set_rx(1'b0, d[4]);
    hold(BIT / 2);
    chk("midframe_busy", 32'(busy_np), 32'd1);
    set_rx(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_outs_zero("midframe_reset");
    hold(3);
    rst = 1'b0;
    last_np = 8'h00;
    last_pe = 8'h00;
    hold(10 * BIT);
    chk("held_low_busy", 32'(busy_np), 32'd0);
    set_rx(1'b0, 1'b1);
    hold(BIT);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    hold(BIT);

    // Randomized frames on both receivers
    for (int n = 0; n < 40; n++) begin
      pe = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 5) != 0);
      send_frame(pe, d, pb, sb);
      hold((sb ? $urandom_range(0, 2) : $urandom_range(1, 2)) * BIT);
    end

    // Drain outstanding expectations with a bounded wait
    wait_cyc = 0;
    while ((q_np.size() != 0 || q_pe.size() != 0) && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    hold(BIT);
    chk("final_np_queue", q_np.size(), 32'd0);
    chk("final_pe_queue", q_pe.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
